// File: rtl/recon_cordic_engine.sv
// Iterative reconfigurable CORDIC: linear MAC, linear divide, hyperbolic and
// circular rotation, one micro-rotation per clock, valid/ready on both sides.
module recon_cordic_engine #(
  parameter int WIDTH = 15,
  parameter int FRAC  = 10,
  parameter int ITER  = 12,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             ext_reset_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH:0]   Xo,
  input  logic [WIDTH:0]   Yo,
  input  logic [WIDTH:0]   Zo,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   x,
  output logic [WIDTH:0]   y,
  output logic [WIDTH:0]   z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int DW = WIDTH + 1 + GUARD;
  localparam logic [4:0] LIN_LAST = 5'(ITER - 1);
  localparam logic [4:0] HYP_LAST = 5'(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [1:0] rst_sync;
  logic       rst_n;

  logic signed [DW-1:0] xr, yr, zr;
  logic signed [DW-1:0] xs, ys, ei, xn, yn, zn;
  logic [1:0]           mode;
  logic [4:0]           iter;
  logic                 rep, d_pos, hold_i, last, accept;
  logic [WIDTH+1:0]     sx, sy, sz;

  // atan / atanh(2^-i) at 16 fractional bits; both round to 2^(16-i) from i=6 up
  function automatic logic [16:0] rot_tab(input logic hyp, input logic [4:0] i);
    logic [16:0] tab;
    tab = 17'd65536 >> i;
    case (i)
      5'd0: tab = hyp ? 17'd0     : 17'd51472;
      5'd1: tab = hyp ? 17'd35999 : 17'd30386;
      5'd2: tab = hyp ? 17'd16739 : 17'd16055;
      5'd3: tab = hyp ? 17'd8235  : 17'd8150;
      5'd4: tab = hyp ? 17'd4101  : 17'd4091;
      5'd5: tab = hyp ? 17'd2049  : 17'd2047;
      default: ;
    endcase
    return tab;
  endfunction

  function automatic logic signed [DW-1:0] step_angle(input logic [1:0] m, input logic [4:0] i);
    logic [31:0] t;
    if (m[1]) t = {15'd0, rot_tab(~m[0], i)} >> (16 - FRAC);
    else      t = (32'd1 << FRAC) >> i;
    return $signed(DW'(t));
  endfunction

  // Returns {clamped, value}: clamps to the [WIDTH:0] two's complement range
  function automatic logic [WIDTH+1:0] sat(input logic signed [DW-1:0] v);
    if (v[DW-1:WIDTH] == {(GUARD+1){v[DW-1]}}) return {1'b0, v[WIDTH:0]};
    else                                      return {1'b1, v[DW-1], {WIDTH{~v[DW-1]}}};
  endfunction

  always_ff @(posedge clk or negedge ext_reset_n)
    if (!ext_reset_n) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    xs     = xr >>> iter;
    ys     = yr >>> iter;
    ei     = step_angle(mode, iter);
    // vectoring drives y toward zero; rotation drives z toward zero
    d_pos  = (mode == 2'b01) ? (xr[DW-1] ^ yr[DW-1]) : ~zr[DW-1];
    yn     = d_pos ? yr + xs : yr - xs;
    zn     = d_pos ? zr - ei : zr + ei;
    case (mode)
      2'b11:   xn = d_pos ? xr - ys : xr + ys;
      2'b10:   xn = d_pos ? xr + ys : xr - ys;
      default: xn = xr;
    endcase
    hold_i = (mode == 2'b10) && ((iter == 5'd4) || (iter == 5'd13)) && !rep;
    last   = (mode == 2'b10) ? ((iter == HYP_LAST) && !hold_i) : (iter == LIN_LAST);
    sx     = sat(xn);
    sy     = sat(yn);
    sz     = sat(zn);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      iter  <= 5'd0;
      rep   <= 1'b0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        iter <= (sel == 2'b10) ? 5'd1 : 5'd0;
        rep  <= 1'b0;
      end else if (state == RUN) begin
        if (hold_i) rep <= 1'b1;
        else begin
          iter <= iter + 5'd1;
          rep  <= 1'b0;
        end
      end
      if ((state == RUN) && last) begin
        x   <= sx[WIDTH:0];
        y   <= sy[WIDTH:0];
        z   <= sz[WIDTH:0];
        ovf <= sx[WIDTH+1] | sy[WIDTH+1] | sz[WIDTH+1];
      end
    end

  always_ff @(posedge clk)
    if (accept) begin
      xr   <= {{GUARD{Xo[WIDTH]}}, Xo};
      yr   <= {{GUARD{Yo[WIDTH]}}, Yo};
      zr   <= {{GUARD{Zo[WIDTH]}}, Zo};
      mode <= sel;
    end else if (state == RUN) begin
      xr <= xn;
      yr <= yn;
      zr <= zn;
    end

endmodule

// File: tb/tb_recon_cordic_engine.sv
// Scoreboard bench for recon_cordic_engine: directed jobs push expectations,
// a negedge monitor pops and compares each accepted result.
module tb_recon_cordic_engine;

  logic        clk = 1'b0;
  logic        ext_reset_n;
  logic [1:0]  sel;
  logic [15:0] Xo, Yo, Zo;
  logic        in_valid, in_ready;
  logic [15:0] x, y, z;
  logic        out_valid, out_ready, ovf;

  recon_cordic_engine dut (
    .clk(clk), .ext_reset_n(ext_reset_n), .sel(sel),
    .Xo(Xo), .Yo(Yo), .Zo(Zo),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int ex, tx, ey, ty, ez, tz;
    int eovf;
    int lat;
    int t_hs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int expv, input int tol);
    int diff;
    diff = act - expv;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", n, act, expv, tol);
    end
  endtask

  function automatic exp_t mk(input string n, input int ex, input int tx, input int ey,
                              input int ty, input int ez, input int tz, input int eovf,
                              input int lat);
    exp_t e;
    e.name = n; e.ex = ex; e.tx = tx; e.ey = ey; e.ty = ty; e.ez = ez; e.tz = tz;
    e.eovf = eovf; e.lat = lat; e.t_hs = 0;
    return e;
  endfunction

  // Monitor: one pop per accepted output word
  always @(negedge clk) begin
    if (!ext_reset_n) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) rise = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_x"}, int'($signed(x)), e.ex, e.tx);
          chk({e.name, "_y"}, int'($signed(y)), e.ey, e.ty);
          chk({e.name, "_z"}, int'($signed(z)), e.ez, e.tz);
          chk({e.name, "_ovf"}, int'(ovf), e.eovf, 0);
          chk({e.name, "_latency"}, rise - e.t_hs, e.lat, 0);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] s, input logic [15:0] xi, input logic [15:0] yi,
                       input logic [15:0] zi, input exp_t e, input bit push, output int t_hs);
    int n;
    n = 0;
    t_hs = -1;
    sel = s; Xo = xi; Yo = yi; Zo = zi; in_valid = 1'b1;
    while (t_hs < 0 && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        t_hs = cyc;
        if (push) begin
          e.t_hs = cyc;
          sb.push_back(e);
        end
      end
      n++;
    end
    if (t_hs < 0) chk("accept_timeout", 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int th, c0, seen, n;
    exp_t none;
    none = mk("none", 0, 0, 0, 0, 0, 0, 0, 0);
    ext_reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel = 2'b00; Xo = '0; Yo = '0; Zo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_x", int'(x), 0, 0);
    chk("rst_y", int'(y), 0, 0);
    chk("rst_z", int'(z), 0, 0);
    chk("rst_ovf", int'(ovf), 0, 0);
    ext_reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    issue(2'b00, 16'h0200, 16'h0080, 16'h0100, mk("mac", 512, 0, 256, 2, 0, 2, 0, 13), 1'b1, th);
    drain();
    issue(2'b01, 16'h0400, 16'h0200, 16'h0000, mk("div", 1024, 0, 0, 2, 512, 2, 0, 13), 1'b1, th);
    drain();
    issue(2'b11, 16'h026E, 16'h0000, 16'h0218, mk("circ", 887, 3, 512, 3, 0, 2, 0, 13), 1'b1, th);
    drain();
    issue(2'b10, 16'h04D4, 16'h0000, 16'h0200, mk("hyp", 1155, 3, 534, 3, 0, 2, 0, 14), 1'b1, th);
    drain();

    // Reset in the middle of a run: outputs clear at once, no stale result later
    issue(2'b00, 16'h0400, 16'h0000, 16'h0200, none, 1'b0, th);
    repeat (4) @(posedge clk);
    #1;
    ext_reset_n = 1'b0;
    #1;
    chk("midrun_out_valid", int'(out_valid), 0, 0);
    chk("midrun_in_ready", int'(in_ready), 1, 0);
    chk("midrun_x", int'(x), 0, 0);
    chk("midrun_y", int'(y), 0, 0);
    chk("midrun_z", int'(z), 0, 0);
    chk("midrun_ovf", int'(ovf), 0, 0);
    repeat (2) @(posedge clk);
    #1;
    ext_reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_result", seen, 0, 0);
    @(posedge clk); #1;

    // Saturation with backpressure, then same-cycle accept of the next job
    out_ready = 1'b0;
    issue(2'b00, 16'h4000, 16'h4000, 16'h0600, mk("sat", 16384, 0, 32767, 0, 0, 2, 1, 13), 1'b1, th);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("sat_valid_timeout", 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1, 0);
      chk("hold_x", int'(x), 16'h4000, 0);
      chk("hold_y", int'(y), 16'h7FFF, 0);
      chk("hold_ovf", int'(ovf), 1, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    c0 = cyc;
    issue(2'b00, 16'h0400, 16'h0000, 16'h0200, mk("mac2", 1024, 0, 512, 2, 0, 2, 0, 13), 1'b1, th);
    chk("accept_same_cycle", th, c0, 0);
    chk("busy_after_accept", int'(out_valid), 0, 0);
    chk("ready_while_run", int'(in_ready), 0, 0);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
